// File: rtl/pp_sequencer.sv
// Session controller for the SMA / second-moment preprocessor: flushes it on
// start, feeds it accepted ticks, and tracks window fill and output validity.
module pp_sequencer #(
  parameter int DATA_WIDTH   = 8,
  parameter int PIPE_LAT     = 2,
  parameter int FLUSH_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  tick_valid,
  input  logic [DATA_WIDTH-1:0] tick_data,
  output logic                  tick_ready,
  output logic                  pp_enable,
  output logic [DATA_WIDTH-1:0] pp_data,
  output logic                  pp_rst,
  output logic [5:0]            win_ready,
  output logic                  mom_ready,
  output logic                  feat_valid,
  output logic [7:0]            sample_count,
  output logic [1:0]            state
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FLUSH  = 2'd1;
  localparam logic [1:0] S_WARMUP = 2'd2;
  localparam logic [1:0] S_RUN    = 2'd3;

  localparam int FC_W = $clog2(FLUSH_CYCLES + 1);

  logic [FC_W-1:0]     flush_cnt;
  logic [PIPE_LAT-1:0] lat_pipe;
  logic [1:0]          state_nxt;
  logic                flush_entry;
  logic                flush_done;
  logic                accept;
  logic [7:0]          count_inc;
  logic [5:0]          win_hits;

  assign tick_ready = (state == S_WARMUP || state == S_RUN) && !stop && !start;
  assign accept     = tick_valid && tick_ready;
  assign count_inc  = (sample_count == 8'hFF) ? 8'hFF : sample_count + 8'd1;
  assign flush_done = (flush_cnt == FC_W'(FLUSH_CYCLES - 1));
  assign feat_valid = lat_pipe[PIPE_LAT-1];

  // Bit i of win_hits corresponds to window {5,10,20,50,100,200}[i].
  assign win_hits = {count_inc >= 8'd200, count_inc >= 8'd100, count_inc >= 8'd50,
                     count_inc >= 8'd20,  count_inc >= 8'd10,  count_inc >= 8'd5};

  // Start wins over stop only from IDLE; in an active session stop wins.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        if (stop)            state_nxt = S_IDLE;
        else if (start)      state_nxt = S_FLUSH;
        else if (flush_done) state_nxt = S_WARMUP;
      end
      S_WARMUP: begin
        if (stop)                         state_nxt = S_IDLE;
        else if (start)                   state_nxt = S_FLUSH;
        else if (accept && win_hits[5])   state_nxt = S_RUN;
      end
      S_RUN: begin
        if (stop)       state_nxt = S_IDLE;
        else if (start) state_nxt = S_FLUSH;
      end
    endcase
  end

  // A restart from within FLUSH counts as a fresh entry.
  assign flush_entry = (state_nxt == S_FLUSH) && ((state != S_FLUSH) || start);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      flush_cnt    <= '0;
      lat_pipe     <= '0;
      pp_enable    <= 1'b0;
      pp_data      <= '0;
      pp_rst       <= 1'b0;
      win_ready    <= 6'd0;
      mom_ready    <= 1'b0;
      sample_count <= 8'd0;
    end else begin
      state     <= state_nxt;
      pp_rst    <= (state_nxt == S_FLUSH);
      pp_enable <= accept;
      if (accept) pp_data <= tick_data;

      if (flush_entry)           flush_cnt <= '0;
      else if (state == S_FLUSH) flush_cnt <= flush_cnt + FC_W'(1);

      // Entering FLUSH discards any pulse still travelling through the latency pipe.
      if (flush_entry) lat_pipe <= '0;
      else             lat_pipe <= (lat_pipe << 1) | PIPE_LAT'(pp_enable);

      if (flush_entry) begin
        sample_count <= 8'd0;
        win_ready    <= 6'd0;
        mom_ready    <= 1'b0;
      end else if (accept) begin
        sample_count <= count_inc;
        win_ready    <= win_ready | win_hits;
        mom_ready    <= mom_ready | (count_inc >= 8'd20);
      end
    end
  end

endmodule

// File: doc/pp_sequencer.md
Name: pp_sequencer

Overview:
- Controller for the SMA/second-moment preprocessing datapath.
- Accepts a market tick stream over a valid/ready handshake and issues one-cycle enable pulses with registered data to the preprocessor.
- Soft-resets the preprocessor on each start, tracks warm-up, and reports which SMA windows (5/10/20/50/100/200) and the 20-sample second moment hold full-window results.
- Flags when preprocessor outputs are valid for the downstream strategy logic.

Parameters:
DATA_WIDTH, 8, tick/data width
PIPE_LAT, 2, cycles from pp_enable pulse to preprocessor outputs valid (>=1)
FLUSH_CYCLES, 4, cycles pp_rst is held high per start (>=1)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
start  in  1  pulse: begin or restart a session
stop  in  1  pulse: end session
tick_valid  in  1  upstream tick present
tick_data  in  DATA_WIDTH  upstream tick price
tick_ready  out  1  sequencer accepts tick this cycle (combinational)
pp_enable  out  1  one-cycle enable to preprocessor
pp_data  out  DATA_WIDTH  registered tick for preprocessor data_in
pp_rst  out  1  soft reset to preprocessor
win_ready  out  6  bit i set = window {5,10,20,50,100,200}[i] filled
mom_ready  out  1  second-moment window (20) filled
feat_valid  out  1  preprocessor outputs valid this cycle
sample_count  out  8  accepted samples since start, saturates at 255
state  out  2  0 IDLE, 1 FLUSH, 2 WARMUP, 3 RUN

Behaviour:
- Reset (async, rst=1):
  - state=IDLE.
  - All outputs 0: pp_enable, pp_data, pp_rst, win_ready, mom_ready, feat_valid, sample_count.
  - Flush counter and latency pipe cleared.
- tick_ready = (state==WARMUP || state==RUN) && !stop && !start.
- Accept = tick_valid && tick_ready.
- IDLE:
  - start -> FLUSH. stop ignored.
  - win_ready, mom_ready and sample_count hold their last values.
- FLUSH:
  - pp_rst=1 (registered, asserted the cycle FLUSH is entered) for exactly FLUSH_CYCLES cycles, then -> WARMUP with pp_rst=0.
  - On entry: sample_count, win_ready, mom_ready and the latency pipe are cleared.
  - start while in FLUSH restarts the count.
  - stop -> IDLE, pp_rst deasserts next cycle.
- WARMUP / RUN, on accept:
  - Next cycle: pp_enable=1 and pp_data=tick_data. pp_enable is otherwise 0 and pp_data holds.
  - sample_count increments (saturating at 255) in the same edge.
  - win_ready[i] sets on the edge where the new count >= window i; mom_ready sets when the new count >= 20. Bits are sticky until the next FLUSH entry.
- WARMUP -> RUN on the edge where the count reaches 200 (win_ready==6'h3F). Same edge as the final win_ready bit.
- feat_valid: pp_enable delayed exactly PIPE_LAT cycles via a shift register.
  - Not gated by state; an in-flight pulse drains after stop.
  - Cleared by rst and by FLUSH entry.
- start in WARMUP/RUN -> FLUSH (restart). No tick is accepted that cycle.
- stop in WARMUP/RUN -> IDLE next cycle. No tick is accepted that cycle.
- Simultaneous start and stop:
  - IDLE: start wins -> FLUSH.
  - FLUSH/WARMUP/RUN: stop wins -> IDLE.
- Back-to-back accepts every cycle are supported (pp_enable high continuously).
- state=3 is reached only from WARMUP. There are no illegal encodings; decode all 4.

Test Plan:
1. rst pulse mid-RUN with tick_valid=1 -> all outputs 0 and state=0 immediately (asynchronous, before the next clk edge); tick_ready=0.
2. start in IDLE, FLUSH_CYCLES=4 -> pp_rst high exactly 4 cycles, state 1 for 4 cycles then 2; tick_ready=0 throughout FLUSH.
3. After flush, 5 consecutive ticks 10,20,30,40,50 -> pp_enable high 5 cycles, each one cycle after its accept; pp_data follows 10..50; win_ready=6'b000001 on the 5th accept edge; feat_valid high 5 cycles starting 2 cycles after the first pp_enable (PIPE_LAT=2).
4. 200 ticks with tick_valid toggled 1,0 alternately -> win_ready sets bits at counts 5,10,20,50,100,200; mom_ready sets at count 20; state goes 2->3 at count 200; continue to 300 ticks -> sample_count=255 (saturated).
5. stop and tick_valid asserted in the same RUN cycle -> no accept, state=IDLE next cycle; the last in-flight feat_valid still appears PIPE_LAT cycles after its pp_enable; win_ready stays 6'h3F in IDLE.
6. start and stop together in WARMUP -> IDLE. Then start alone -> FLUSH, with win_ready, mom_ready and sample_count cleared on the first FLUSH cycle.
